axi_lite_cpu_bridge: RTL and testbench

Parametrised AXI4-Lite slave that converts host register accesses into the single-cycle CPU strobe interface used around the system, generalised to several targets. Address bits above the region field select one of NUM_TARGETS targets; unmapped indices return DECERR. The block adds byte strobes, a configurable target read latency, and fair read/write arbitration. It sits between the host AXI-Lite interconnect and the Flipper peripheral register files.

---
 rtl/axi_lite_cpu_bridge.sv | 184 ++++++++++++++++++
 tb/tb_axi_lite_cpu_bridge.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_cpu_bridge.sv
// AXI4-Lite slave that turns host register accesses into single-cycle CPU strobes to one of
// NUM_TARGETS register files. One transaction in flight at a time. Reads and writes are
// arbitrated fairly when both are pending, and the target read latency is configurable.
module axi_lite_cpu_bridge #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned REGION_BITS = 16,
  parameter int unsigned NUM_TARGETS = 4,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  // write address / data / response
  input  logic [ADDR_W-1:0]             awaddr,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [DATA_W/8-1:0]           wstrb,
  input  logic                          wvalid,
  output logic                          wready,
  output logic [1:0]                    bresp,
  output logic                          bvalid,
  input  logic                          bready,
  // read address / data
  input  logic [ADDR_W-1:0]             araddr,
  input  logic                          arvalid,
  output logic                          arready,
  output logic [DATA_W-1:0]             rdata,
  output logic [1:0]                    rresp,
  output logic                          rvalid,
  input  logic                          rready,
  // CPU strobe side
  output logic                          cpu_read,
  output logic                          cpu_write,
  output logic [NUM_TARGETS-1:0]        cpu_select,
  output logic [REGION_BITS-1:0]        cpu_address,
  output logic [DATA_W-1:0]             cpu_write_data,
  output logic [DATA_W/8-1:0]           cpu_wstrb,
  input  logic [NUM_TARGETS*DATA_W-1:0] cpu_read_data
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned IdxW  = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  // Final RD_WAIT count; unused when RD_LATENCY is zero.
  localparam logic [2:0] CntLast = 3'((RD_LATENCY == 0) ? 0 : RD_LATENCY - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWrAccept,
    StWrResp,
    StRdAccept,
    StRdWait,
    StRdResp
  } state_e;

  state_e                 state_q, state_d;
  logic                   last_wr_q, last_wr_d;  // 1: write won the last conflict
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [REGION_BITS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [StrbW-1:0]       wstrb_q, wstrb_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic [2:0]             cnt_q, cnt_d;

  logic                   wr_pend, rd_pend;
  logic                   mapped;
  logic [DATA_W-1:0]      sel_data;
  logic [NUM_TARGETS-1:0] sel_onehot;
  logic                   unused_addr;

  assign wr_pend = awvalid && wvalid;
  assign rd_pend = arvalid;
  assign mapped  = 32'(idx_q) < NUM_TARGETS;

  // Only the region offset and target index are decoded; the rest of the address is ignored.
  assign unused_addr = ^{awaddr, araddr};

  // Decode the registered index into a one-hot select and the matching read-data slice.
  always_comb begin
    sel_data   = '0;
    sel_onehot = '0;
    for (int unsigned t = 0; t < NUM_TARGETS; t++) begin
      if (32'(idx_q) == t) begin
        sel_data      = cpu_read_data[t*DATA_W +: DATA_W];
        sel_onehot[t] = 1'b1;
      end
    end
  end

  // Next-state logic: arbitration, request capture, read latency counting and data capture.
  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        // A conflict goes to whichever side lost the previous conflict.
        if (rd_pend && (!wr_pend || last_wr_q)) begin
          state_d = StRdAccept;
          idx_d   = araddr[REGION_BITS +: IdxW];
          addr_d  = araddr[REGION_BITS-1:0];
          if (wr_pend) last_wr_d = 1'b0;
        end else if (wr_pend) begin
          state_d = StWrAccept;
          idx_d   = awaddr[REGION_BITS +: IdxW];
          addr_d  = awaddr[REGION_BITS-1:0];
          wdata_d = wdata;
          wstrb_d = wstrb;
          if (rd_pend) last_wr_d = 1'b1;
        end
      end
      StWrAccept: state_d = StWrResp;
      StWrResp: begin
        if (bready) state_d = StIdle;
      end
      StRdAccept: begin
        cnt_d = '0;
        if (RD_LATENCY == 0) begin
          rdata_d = sel_data;
          state_d = StRdResp;
        end else begin
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (cnt_q == CntLast) begin
          rdata_d = sel_data;
          state_d = StRdResp;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StRdResp: begin
        if (rready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and captured-request registers; reset also drops any pending response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      last_wr_q <= 1'b1;
      idx_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  // All outputs are decoded from registered state only.
  assign awready        = (state_q == StWrAccept);
  assign wready         = (state_q == StWrAccept);
  assign bvalid         = (state_q == StWrResp);
  assign bresp          = (state_q == StWrResp && !mapped) ? 2'b11 : 2'b00;
  assign arready        = (state_q == StRdAccept);
  assign rvalid         = (state_q == StRdResp);
  assign rresp          = (state_q == StRdResp && !mapped) ? 2'b11 : 2'b00;
  assign rdata          = rdata_q;
  assign cpu_write      = (state_q == StWrAccept) && mapped && (|wstrb_q);
  assign cpu_read       = (state_q == StRdAccept) && mapped;
  assign cpu_select     = (cpu_read || cpu_write) ? sel_onehot : '0;
  assign cpu_address    = addr_q;
  assign cpu_write_data = wdata_q;
  assign cpu_wstrb      = wstrb_q;

endmodule

// File: tb/tb_axi_lite_cpu_bridge.sv
// Self-checking bench for axi_lite_cpu_bridge. Three instances cover 4 targets / latency 1,
// 4 targets / latency 0 and 3 targets / latency 3. A table of directed vectors, fairness and
// reset sequences and random traffic are checked against a small address-decode model.
module tb_axi_lite_cpu_bridge;

  localparam int NI = 3;
  localparam int NV = 11;

  logic clk;
  logic         reset          [NI];
  logic [31:0]  awaddr         [NI];
  logic         awvalid        [NI];
  logic         awready        [NI];
  logic [31:0]  wdata          [NI];
  logic [3:0]   wstrb          [NI];
  logic         wvalid         [NI];
  logic         wready         [NI];
  logic [1:0]   bresp          [NI];
  logic         bvalid         [NI];
  logic         bready         [NI];
  logic [31:0]  araddr         [NI];
  logic         arvalid        [NI];
  logic         arready        [NI];
  logic [31:0]  rdata          [NI];
  logic [1:0]   rresp          [NI];
  logic         rvalid         [NI];
  logic         rready         [NI];
  logic         cpu_read       [NI];
  logic         cpu_write      [NI];
  logic [3:0]   cpu_select     [NI];
  logic [15:0]  cpu_address    [NI];
  logic [31:0]  cpu_write_data [NI];
  logic [3:0]   cpu_wstrb      [NI];
  logic [127:0] rd_bus         [NI];
  logic [31:0]  tgt            [NI][4];

  int checks = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int i, input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL i%0d %s: actual=0x%0h expected=0x%0h", i, nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned Nt  = (g == 2) ? 3 : 4;
    localparam int unsigned Lat = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    logic [Nt-1:0]    sel_w;
    logic [Nt*32-1:0] rd_w;
    assign rd_w          = rd_bus[g][Nt*32-1:0];
    assign cpu_select[g] = 4'(sel_w);

    axi_lite_cpu_bridge #(
      .DATA_W(32), .ADDR_W(32), .REGION_BITS(16), .NUM_TARGETS(Nt), .RD_LATENCY(Lat)
    ) u_dut (
      .clk(clk), .reset(reset[g]),
      .awaddr(awaddr[g]), .awvalid(awvalid[g]), .awready(awready[g]),
      .wdata(wdata[g]), .wstrb(wstrb[g]), .wvalid(wvalid[g]), .wready(wready[g]),
      .bresp(bresp[g]), .bvalid(bvalid[g]), .bready(bready[g]),
      .araddr(araddr[g]), .arvalid(arvalid[g]), .arready(arready[g]),
      .rdata(rdata[g]), .rresp(rresp[g]), .rvalid(rvalid[g]), .rready(rready[g]),
      .cpu_read(cpu_read[g]), .cpu_write(cpu_write[g]), .cpu_select(sel_w),
      .cpu_address(cpu_address[g]), .cpu_write_data(cpu_write_data[g]),
      .cpu_wstrb(cpu_wstrb[g]), .cpu_read_data(rd_w)
    );

    // Strobe invariants hold in every cycle.
    always @(negedge clk) begin
      chk(g, "strobe_overlap", cpu_read[g] & cpu_write[g], 0);
      if (cpu_read[g] || cpu_write[g]) chk(g, "select_onehot", $onehot(cpu_select[g]), 1);
      else chk(g, "select_idle", cpu_select[g], 0);
    end
  end

  // Instance configuration as the model sees it.
  function automatic int nt_of(input int i);
    return (i == 2) ? 3 : 4;
  endfunction
  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  task automatic load_bus(input int i);
    for (int k = 0; k < 4; k++) rd_bus[i][k*32 +: 32] = tgt[i][k];
  endtask

  task automatic do_write(input int i, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int bdly, input logic exp_wr,
                          input logic [3:0] exp_sel, input logic [1:0] exp_resp);
    awaddr[i] = a; wdata[i] = d; wstrb[i] = s;
    awvalid[i] = 1'b1; wvalid[i] = 1'b1; bready[i] = (bdly == 0);
    @(negedge clk);
    chk(i, "wr_awready", awready[i], 1);
    chk(i, "wr_wready", wready[i], 1);
    chk(i, "wr_strobe", cpu_write[i], exp_wr);
    chk(i, "wr_select", cpu_select[i], exp_sel);
    chk(i, "wr_bvalid_early", bvalid[i], 0);
    chk(i, "wr_no_rvalid", rvalid[i], 0);
    if (exp_wr) begin
      chk(i, "wr_address", cpu_address[i], a[15:0]);
      chk(i, "wr_data", cpu_write_data[i], d);
      chk(i, "wr_wstrb", cpu_wstrb[i], s);
    end
    @(negedge clk);
    awvalid[i] = 1'b0; wvalid[i] = 1'b0;
    chk(i, "wr_bvalid", bvalid[i], 1);
    chk(i, "wr_bresp", bresp[i], exp_resp);
    chk(i, "wr_strobe_once", cpu_write[i], 0);
    chk(i, "wr_awready_once", awready[i], 0);
    repeat (bdly) begin
      @(negedge clk);
      chk(i, "wr_bvalid_hold", bvalid[i], 1);
      chk(i, "wr_bresp_hold", bresp[i], exp_resp);
    end
    bready[i] = 1'b1;
    @(negedge clk);
    chk(i, "wr_bvalid_end", bvalid[i], 0);
    bready[i] = 1'b0;
  endtask

  task automatic do_read(input int i, input logic [31:0] a, input int rdly,
                         input logic exp_rd, input logic [3:0] exp_sel,
                         input logic [1:0] exp_resp, input logic [31:0] exp_data,
                         input int lat);
    araddr[i] = a; arvalid[i] = 1'b1; rready[i] = (rdly == 0);
    @(negedge clk);
    chk(i, "rd_arready", arready[i], 1);
    chk(i, "rd_strobe", cpu_read[i], exp_rd);
    chk(i, "rd_select", cpu_select[i], exp_sel);
    chk(i, "rd_rvalid_early", rvalid[i], 0);
    if (exp_rd) chk(i, "rd_address", cpu_address[i], a[15:0]);
    @(negedge clk);
    arvalid[i] = 1'b0;
    repeat (lat) begin
      chk(i, "rd_rvalid_wait", rvalid[i], 0);
      chk(i, "rd_strobe_once", cpu_read[i], 0);
      @(negedge clk);
    end
    chk(i, "rd_rvalid", rvalid[i], 1);
    chk(i, "rd_rdata", rdata[i], exp_data);
    chk(i, "rd_rresp", rresp[i], exp_resp);
    repeat (rdly) begin
      // Targets change after capture; the response must not follow them.
      rd_bus[i] = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk(i, "rd_rvalid_hold", rvalid[i], 1);
      chk(i, "rd_rdata_hold", rdata[i], exp_data);
      chk(i, "rd_rresp_hold", rresp[i], exp_resp);
    end
    load_bus(i);
    rready[i] = 1'b1;
    @(negedge clk);
    chk(i, "rd_rvalid_end", rvalid[i], 0);
    rready[i] = 1'b0;
  endtask

  // Both channels held pending: grants must alternate starting with the read.
  task automatic arb_test(input int i);
    int  grants;
    logic exp_read;
    grants = 0;
    exp_read = 1'b1;
    awaddr[i] = 32'h0001_0004; wdata[i] = 32'h0BAD_F00D; wstrb[i] = 4'hF;
    araddr[i] = 32'h0000_0008;
    awvalid[i] = 1'b1; wvalid[i] = 1'b1; arvalid[i] = 1'b1;
    bready[i] = 1'b1; rready[i] = 1'b1;
    for (int c = 0; c < 60 && grants < 4; c++) begin
      @(negedge clk);
      if (arready[i] || awready[i]) begin
        chk(i, "arb_read_granted", arready[i], exp_read);
        chk(i, "arb_write_granted", awready[i], !exp_read);
        chk(i, "arb_strobe", {cpu_read[i], cpu_write[i]}, exp_read ? 2'b10 : 2'b01);
        exp_read = !exp_read;
        grants++;
        if (grants == 4) begin
          awvalid[i] = 1'b0; wvalid[i] = 1'b0; arvalid[i] = 1'b0;
        end
      end
    end
    chk(i, "arb_grant_count", grants, 4);
    awvalid[i] = 1'b0; wvalid[i] = 1'b0; arvalid[i] = 1'b0;
    repeat (8) @(negedge clk);
    chk(i, "arb_drain_bvalid", bvalid[i], 0);
    chk(i, "arb_drain_rvalid", rvalid[i], 0);
    bready[i] = 1'b0; rready[i] = 1'b0;
  endtask

  typedef struct {
    int          inst;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  ws;
    int          dly;
    logic        exp_strobe;
    logic [3:0]  exp_sel;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    int          i, idx;
    logic        wr, mapped;
    logic [31:0] a, d;
    logic [3:0]  s, sel;

    vecs[0]  = '{0, 1'b1, 32'h0001_0040, 32'hDEAD_BEEF, 4'hF, 0, 1'b1, 4'b0010, 2'b00, 0, 0};
    vecs[1]  = '{0, 1'b0, 32'h0002_0010, 32'h0, 4'h0, 0, 1'b1, 4'b0100, 2'b00, 32'h1234_5678, 1};
    vecs[2]  = '{1, 1'b0, 32'h0002_0010, 32'h0, 4'h0, 0, 1'b1, 4'b0100, 2'b00, 32'h1234_5678, 0};
    vecs[3]  = '{2, 1'b0, 32'h0003_0000, 32'h0, 4'h0, 0, 1'b0, 4'b0000, 2'b11, 32'h0, 3};
    vecs[4]  = '{2, 1'b1, 32'h0003_0000, 32'h55, 4'hF, 0, 1'b0, 4'b0000, 2'b11, 0, 0};
    vecs[5]  = '{0, 1'b1, 32'h0000_0100, 32'h7777_7777, 4'h0, 1, 1'b0, 4'b0000, 2'b00, 0, 0};
    vecs[6]  = '{0, 1'b0, 32'h0001_0020, 32'h0, 4'h0, 5, 1'b1, 4'b0010, 2'b00, 32'hB1B1_B1B1, 1};
    vecs[7]  = '{2, 1'b0, 32'h0002_0004, 32'h0, 4'h0, 2, 1'b1, 4'b0100, 2'b00, 32'h1234_5678, 3};
    vecs[8]  = '{1, 1'b1, 32'hFFFF_3FFC, 32'hA5A5_5A5A, 4'hA, 3, 1'b1, 4'b1000, 2'b00, 0, 0};
    vecs[9]  = '{2, 1'b0, 32'h0004_0000, 32'h0, 4'h0, 0, 1'b1, 4'b0001, 2'b00, 32'hA0A0_A0A0, 3};
    vecs[10] = '{1, 1'b0, 32'h0003_1234, 32'h0, 4'h0, 1, 1'b1, 4'b1000, 2'b00, 32'hC3C3_C3C3, 0};

    for (int n = 0; n < NI; n++) begin
      reset[n] = 1'b1;
      awaddr[n] = '0; awvalid[n] = 1'b0; wdata[n] = '0; wstrb[n] = '0; wvalid[n] = 1'b0;
      bready[n] = 1'b0; araddr[n] = '0; arvalid[n] = 1'b0; rready[n] = 1'b0;
      tgt[n][0] = 32'hA0A0_A0A0; tgt[n][1] = 32'hB1B1_B1B1;
      tgt[n][2] = 32'h1234_5678; tgt[n][3] = 32'hC3C3_C3C3;
      load_bus(n);
    end
    repeat (2) @(negedge clk);
    for (int n = 0; n < NI; n++) begin
      chk(n, "reset_ready", {awready[n], wready[n], arready[n]}, 0);
      chk(n, "reset_valid", {bvalid[n], rvalid[n]}, 0);
      chk(n, "reset_strobe", {cpu_read[n], cpu_write[n], cpu_select[n]}, 0);
      chk(n, "reset_resp", {rdata[n], bresp[n], rresp[n]}, 0);
      reset[n] = 1'b0;
    end
    @(negedge clk);

    arb_test(0);
    arb_test(1);

    for (int v = 0; v < NV; v++) begin
      if (vecs[v].wr)
        do_write(vecs[v].inst, vecs[v].addr, vecs[v].wd, vecs[v].ws, vecs[v].dly,
                 vecs[v].exp_strobe, vecs[v].exp_sel, vecs[v].exp_resp);
      else
        do_read(vecs[v].inst, vecs[v].addr, vecs[v].dly, vecs[v].exp_strobe, vecs[v].exp_sel,
                vecs[v].exp_resp, vecs[v].exp_rdata, vecs[v].exp_lat);
    end

    // Random traffic: expectations come from the address-decode rules.
    for (int n = 0; n < 120; n++) begin
      i      = $urandom_range(0, NI - 1);
      wr     = 1'($urandom_range(0, 1));
      idx    = $urandom_range(0, 3);
      a      = ($urandom & 32'hFFFC_FFFF) | (32'(idx) << 16);
      d      = $urandom;
      s      = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      mapped = (idx < nt_of(i));
      sel    = mapped ? 4'(1 << idx) : 4'h0;
      if (wr) begin
        do_write(i, a, d, s, $urandom_range(0, 3), mapped && (s != 0),
                 (mapped && (s != 0)) ? sel : 4'h0, mapped ? 2'b00 : 2'b11);
      end else begin
        for (int k = 0; k < 4; k++) tgt[i][k] = $urandom;
        load_bus(i);
        do_read(i, a, $urandom_range(0, 3), mapped, sel, mapped ? 2'b00 : 2'b11,
                mapped ? tgt[i][idx] : 32'h0, lat_of(i));
      end
    end

    // Reset while a latency-3 read is waiting on its target.
    tgt[2][1] = 32'h5EED_0001;
    load_bus(2);
    do_read(2, 32'h0001_0008, 0, 1'b1, 4'b0010, 2'b00, 32'h5EED_0001, 3);
    araddr[2] = 32'h0001_0000; arvalid[2] = 1'b1; rready[2] = 1'b0;
    @(negedge clk);
    chk(2, "rst_seq_arready", arready[2], 1);
    @(negedge clk);
    arvalid[2] = 1'b0;
    chk(2, "rst_seq_waiting", rvalid[2], 0);
    reset[2] = 1'b1;
    @(negedge clk);
    chk(2, "rst_seq_ready", {awready[2], wready[2], arready[2]}, 0);
    chk(2, "rst_seq_valid", {bvalid[2], rvalid[2]}, 0);
    chk(2, "rst_seq_strobe", {cpu_read[2], cpu_write[2], cpu_select[2]}, 0);
    chk(2, "rst_seq_rdata", rdata[2], 0);
    chk(2, "rst_seq_resp", {bresp[2], rresp[2]}, 0);
    chk(2, "rst_seq_address", cpu_address[2], 0);
    reset[2] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk(2, "rst_seq_no_stale_rvalid", rvalid[2], 0);
    end
    do_write(2, 32'h0002_0010, 32'hCAFE_F00D, 4'h3, 1, 1'b1, 4'b0100, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
